// File: rtl/fp_to_fixed_pkg.sv
// ---------------------------------------------------------------------------
// fp_to_fixed_pkg
// Shared definitions for the float <-> Q3.16 conversion blocks
// (fp_to_fixed and fixed_to_fp).
//   - IEEE-754 single precision field widths and exponent bias
//   - Q3.16 format widths and saturation limits
//   - FSM state encoding of the float-to-fixed converter
// ---------------------------------------------------------------------------
package fp_to_fixed_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_MANT_W   = 23;
  localparam int FP_EXP_W    = 8;

  localparam int Q_INT_W  = 3;
  localparam int Q_FRAC_W = 16;
  localparam int Q_W      = Q_INT_W + Q_FRAC_W;

  localparam logic [Q_W-1:0] Q_MAX = 19'h3FFFF;
  localparam logic [Q_W-1:0] Q_MIN = 19'h40000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp2fix_state_t;

endpackage

// File: rtl/fp_to_fixed.sv
// ---------------------------------------------------------------------------
// fp_to_fixed
// Iterative IEEE-754 single -> signed Q3.16 converter. The mantissa is
// right-shifted one bit per cycle, then rounded to nearest-even; values
// outside the Q3.16 range saturate.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready only while idle)
//   fp_in[31:0]         float operand
//   out_valid/out_ready result handshake (result held while stalled)
//   fix_out[W-1:0]      signed Q3.16 result
//   ovf                 result saturated (or Inf/NaN input)
//   nan                 input was NaN
//   inexact             nonzero bits discarded or saturation occurred
// ---------------------------------------------------------------------------
module fp_to_fixed
  import fp_to_fixed_pkg::*;
#(
  parameter int FRAC_W = 16,
  parameter int INT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             fp_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] fix_out,
  output logic                    ovf,
  output logic                    nan,
  output logic                    inexact
);

  localparam int W = INT_W + FRAC_W;
  // Shift count that aligns the 24-bit mantissa to the fixed-point LSB:
  // r = (bias + mantissa bits - fraction bits) - e.
  localparam logic [7:0] R_BASE = 8'(FP_EXP_BIAS + FP_MANT_W - FRAC_W);
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  fp2fix_state_t state_reg;
  logic [23:0]   shreg_reg;
  logic [4:0]    cnt_reg;
  logic          guard_reg;
  logic          sticky_reg;
  logic          sign_reg;
  logic [W-1:0]  fix_reg;
  logic          ovf_reg;
  logic          nan_reg;
  logic          inexact_reg;

  // ---- accept-time decode ----
  logic [7:0]   exp_in;
  logic         sign_in;
  logic         mant_zero;
  logic [7:0]   r_full;
  logic         dec_special;
  logic [W-1:0] dec_fix;
  logic         dec_ovf;
  logic         dec_nan;
  logic         dec_inexact;

  assign exp_in    = fp_in[30:23];
  assign sign_in   = fp_in[31];
  assign mant_zero = (fp_in[22:0] == 23'd0);
  assign r_full    = R_BASE - exp_in;

  always_comb begin
    dec_special = 1'b1;
    dec_fix     = '0;
    dec_ovf     = 1'b0;
    dec_nan     = 1'b0;
    dec_inexact = 1'b0;
    if (exp_in == 8'd255 && !mant_zero) begin
      dec_fix     = SAT_POS;
      dec_nan     = 1'b1;
      dec_ovf     = 1'b1;
      dec_inexact = 1'b1;
    end else if (exp_in == 8'd255 ||
                 exp_in >= 8'd130 ||
                 (exp_in == 8'd129 && (!mant_zero || !sign_in))) begin
      dec_fix     = sign_in ? SAT_NEG : SAT_POS;
      dec_ovf     = 1'b1;
      dec_inexact = 1'b1;
    end else if (exp_in == 8'd129) begin
      // exactly -4.0 is representable
      dec_fix = SAT_NEG;
    end else if (exp_in == 8'd0 || r_full >= 8'd25) begin
      // zero, denormal or below half an LSB before rounding; sign dropped
      dec_inexact = (fp_in[30:0] != 31'd0);
    end else begin
      dec_special = 1'b0;
    end
  end

  // ---- rounding of the shifted magnitude ----
  logic         round_up;
  logic [W-1:0] mag;

  assign round_up = guard_reg & (sticky_reg | shreg_reg[0]);
  assign mag      = shreg_reg[W-1:0] + {{(W-1){1'b0}}, round_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      guard_reg   <= 1'b0;
      sticky_reg  <= 1'b0;
      sign_reg    <= 1'b0;
      fix_reg     <= '0;
      ovf_reg     <= 1'b0;
      nan_reg     <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            if (dec_special) begin
              fix_reg     <= dec_fix;
              ovf_reg     <= dec_ovf;
              nan_reg     <= dec_nan;
              inexact_reg <= dec_inexact;
              state_reg   <= ST_DONE;
            end else begin
              shreg_reg  <= {1'b1, fp_in[22:0]};
              cnt_reg    <= r_full[4:0];
              guard_reg  <= 1'b0;
              sticky_reg <= 1'b0;
              sign_reg   <= sign_in;
              state_reg  <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          sticky_reg <= sticky_reg | guard_reg;
          guard_reg  <= shreg_reg[0];
          shreg_reg  <= {1'b0, shreg_reg[23:1]};
          cnt_reg    <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            state_reg <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          nan_reg <= 1'b0;
          if (!sign_reg && mag[W-1]) begin
            // rounded up past the largest positive value
            fix_reg     <= SAT_POS;
            ovf_reg     <= 1'b1;
            inexact_reg <= 1'b1;
          end else begin
            fix_reg     <= sign_reg ? (~mag + {{(W-1){1'b0}}, 1'b1}) : mag;
            ovf_reg     <= 1'b0;
            inexact_reg <= guard_reg | sticky_reg;
          end
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign fix_out   = fix_reg;
  assign ovf       = ovf_reg;
  assign nan       = nan_reg;
  assign inexact   = inexact_reg;

endmodule
